button_debouncer: RTL and testbench

- Upstream conditioning stage for the LED shift-register demo.
- Takes the raw, bouncing, asynchronous push-button and produces clean single-cycle event pulses plus a debounced toggle level.
- The toggle level drives the shift direction input directly, replacing the button-clocked T flip-flop with a fully synchronous path.

---
 rtl/button_debouncer.sv | 145 ++++++++++++++
 tb/tb_button_debouncer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Purpose: turn a raw, bouncing push-button into a debounced level, press/release/long-press pulses and a toggle level.
// Latency: a stable level change is accepted DEBOUNCE_CYCLES+2 edges after the first edge that samples it; all outputs registered.
// Backpressure: none; outputs are free-running levels and single-cycle pulses with no handshake.
//
// Ports:
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   button        raw asynchronous push-button (polarity set by ACTIVE_LOW)
//   btn_state     debounced level, 1 = pressed
//   press_pulse   one-cycle pulse when a press is accepted
//   release_pulse one-cycle pulse when a release is accepted
//   long_press    one-cycle pulse once per press held LONG_PRESS_CYCLES after acceptance
//   toggle        level that inverts on every accepted press
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64,
  parameter int ACTIVE_LOW        = 0,
  parameter int CNT_WIDTH         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic button,
  output logic btn_state,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_press,
  output logic toggle
);

  localparam logic [CNT_WIDTH-1:0] DEB_MAX  = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] HOLD_MAX = CNT_WIDTH'(LONG_PRESS_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Polarity is normalised before the synchronizer so that everything
  // downstream sees 1 = pressed regardless of board wiring.
  logic btn_in;
  assign btn_in = (ACTIVE_LOW != 0) ? ~button : button;

  // Two-flop synchronizer; the only place the asynchronous input is sampled.
  logic sync_meta;
  logic sync_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_meta <= 1'b0;
      sync_btn  <= 1'b0;
    end else begin
      sync_meta <= btn_in;
      sync_btn  <= sync_meta;
    end
  end

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;       // consecutive stable samples of the candidate level
  logic [CNT_WIDTH-1:0] hold_cnt;  // cycles spent pressed since acceptance, saturating

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= CNT_ZERO;
      hold_cnt      <= CNT_ZERO;
      btn_state     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;
      toggle        <= 1'b0;
    end else begin
      // Pulses are single-cycle unless re-asserted below.
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_press    <= 1'b0;

      case (state)
        IDLE: begin
          if (sync_btn) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_ONE;
          end
        end

        PRESS_WAIT: begin
          if (!sync_btn) begin
            // Glitch rejected: drop back without any output change.
            state <= IDLE;
            cnt   <= CNT_ZERO;
          end else if (cnt == DEB_MAX) begin
            state       <= PRESSED;
            cnt         <= CNT_ZERO;
            hold_cnt    <= CNT_ZERO;
            press_pulse <= 1'b1;
            btn_state   <= 1'b1;
            toggle      <= ~toggle;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        PRESSED: begin
          // Saturating hold counter; the pulse fires on the single edge
          // where it reaches the limit, so it cannot repeat within a press.
          if (hold_cnt != HOLD_MAX) begin
            hold_cnt <= hold_cnt + CNT_ONE;
            if (hold_cnt == (HOLD_MAX - CNT_ONE)) begin
              long_press <= 1'b1;
            end
          end
          if (!sync_btn) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_ONE;
          end
        end

        RELEASE_WAIT: begin
          // hold_cnt is frozen here and resumes if the release was a bounce,
          // so a long press already reported stays reported.
          if (sync_btn) begin
            state <= PRESSED;
            cnt   <= CNT_ZERO;
          end else if (cnt == DEB_MAX) begin
            state         <= IDLE;
            cnt           <= CNT_ZERO;
            release_pulse <= 1'b1;
            btn_state     <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= CNT_ZERO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  logic clk;
  logic rst_n;
  logic btn;
  logic btn_n;

  logic st0, pp0, rp0, lp0, tg0;
  logic st1, pp1, rp1, lp1, tg1;

  int n_cmp;
  int n_fail;

  assign btn_n = ~btn;

  button_debouncer #(
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .ACTIVE_LOW(0), .CNT_WIDTH(16)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .button(btn),
    .btn_state(st0), .press_pulse(pp0), .release_pulse(rp0),
    .long_press(lp0), .toggle(tg0)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES(4), .LONG_PRESS_CYCLES(16), .ACTIVE_LOW(1), .CNT_WIDTH(16)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .button(btn_n),
    .btn_state(st1), .press_pulse(pp1), .release_pulse(rp1),
    .long_press(lp1), .toggle(tg1)
  );

  // Output bundle order: {btn_state, press_pulse, release_pulse, long_press, toggle}
  logic [4:0] o0;
  logic [4:0] o1;
  assign o0 = {st0, pp0, rp0, lp0, tg0};
  assign o1 = {st1, pp1, rp1, lp1, tg1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    logic [4:0] exp;
    rst_n = 1'b0;
    btn   = 1'b0;
    exp   = 5'b00000;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (o0 !== exp) begin
      n_fail++;
      $display("FAIL reset_hi: got %b want %b", o0, exp);
    end
    n_cmp++;
    if (o1 !== exp) begin
      n_fail++;
      $display("FAIL reset_lo: got %b want %b", o1, exp);
    end
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL idle_hi cyc %0d: got %b want %b", i, o0, exp);
      end
      n_cmp++;
      if (o1 !== exp) begin
        n_fail++;
        $display("FAIL idle_lo cyc %0d: got %b want %b", i, o1, exp);
      end
    end
  endtask

  // Clean press: first sampling edge is i=1, pulse visible after edge i=7.
  task automatic test_clean_press();
    logic [4:0] exp;
    btn = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk); #1;
      exp = {(i >= 7), (i == 7), 1'b0, 1'b0, (i >= 7)};
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL clean_press_hi cyc %0d: got %b want %b", i, o0, exp);
      end
      n_cmp++;
      if (o1 !== exp) begin
        n_fail++;
        $display("FAIL clean_press_lo cyc %0d: got %b want %b", i, o1, exp);
      end
    end
  endtask

  // Continues holding from the clean press; long_press 16 cycles after press_pulse (i=23).
  task automatic test_long_press();
    logic [4:0] exp;
    for (int i = 13; i <= 46; i++) begin
      @(posedge clk); #1;
      exp = {1'b1, 1'b0, 1'b0, (i == 23), 1'b1};
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL long_hold cyc %0d: got %b want %b", i, o0, exp);
      end
    end
    btn = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      exp = {(j < 7), 1'b0, (j == 7), 1'b0, 1'b1};
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL long_release cyc %0d: got %b want %b", j, o0, exp);
      end
    end
  endtask

  task automatic test_bounce();
    logic [4:0] exp;
    for (int i = 1; i <= 6; i++) begin
      btn = (i % 2 == 1);
      @(posedge clk); #1;
      exp = 5'b00001;
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL bounce cyc %0d: got %b want %b", i, o0, exp);
      end
    end
    btn = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      exp = {(j >= 7), (j == 7), 1'b0, 1'b0, (j < 7)};
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL bounce_settle cyc %0d: got %b want %b", j, o0, exp);
      end
    end
    btn = 1'b0;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      exp = {(j < 7), 1'b0, (j == 7), 1'b0, 1'b0};
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL bounce_release cyc %0d: got %b want %b", j, o0, exp);
      end
    end
  endtask

  // Three short press/release rounds; holds are far shorter than 16 cycles.
  task automatic test_back_to_back();
    logic [4:0] exp;
    logic       told;
    logic       tnew;
    for (int r = 0; r < 3; r++) begin
      told = (r % 2 == 1);
      tnew = ~told;
      btn = 1'b1;
      for (int j = 1; j <= 10; j++) begin
        @(posedge clk); #1;
        exp = {(j >= 7), (j == 7), 1'b0, 1'b0, ((j >= 7) ? tnew : told)};
        n_cmp++;
        if (o0 !== exp) begin
          n_fail++;
          $display("FAIL b2b_press r%0d cyc %0d: got %b want %b", r, j, o0, exp);
        end
      end
      btn = 1'b0;
      for (int j = 1; j <= 10; j++) begin
        @(posedge clk); #1;
        exp = {(j < 7), 1'b0, (j == 7), 1'b0, tnew};
        n_cmp++;
        if (o0 !== exp) begin
          n_fail++;
          $display("FAIL b2b_release r%0d cyc %0d: got %b want %b", r, j, o0, exp);
        end
      end
    end
    n_cmp++;
    if (tg0 !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_toggle_end: got %b want 1", tg0);
    end
  endtask

  task automatic test_reset_mid_press();
    logic [4:0] exp;
    btn = 1'b1;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk); #1;
      exp = {(j >= 7), (j == 7), 1'b0, 1'b0, (j < 7)};
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL rst_pre_press cyc %0d: got %b want %b", j, o0, exp);
      end
    end
    // Assert between edges: outputs must clear without waiting for a clock.
    rst_n = 1'b0;
    #1;
    exp = 5'b00000;
    n_cmp++;
    if (o0 !== exp) begin
      n_fail++;
      $display("FAIL rst_async: got %b want %b", o0, exp);
    end
    for (int j = 1; j <= 2; j++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL rst_hold cyc %0d: got %b want %b", j, o0, exp);
      end
    end
    rst_n = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      @(posedge clk); #1;
      exp = {(j >= 7), (j == 7), 1'b0, 1'b0, (j >= 7)};
      n_cmp++;
      if (o0 !== exp) begin
        n_fail++;
        $display("FAIL rst_repress cyc %0d: got %b want %b", j, o0, exp);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst_n  = 1'b0;
    btn    = 1'b0;
    test_reset();
    test_clean_press();
    test_long_press();
    test_bounce();
    test_back_to_back();
    test_reset_mid_press();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
